// File: rtl/spi_cmd_seq_pkg.sv
// Shared types for the SPI command sequencer: FSM state, queued command and response records.
package spi_cmd_pkg;

    typedef enum logic {
        PARK = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] din;
    } spi_cmd_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] dout;
        logic       err;
    } spi_rsp_t;

    localparam int MEM_WORDS = 32;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO with fall-through head; push is accepted when full if a pop happens in the same cycle.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/spi_cmd_seq.sv
// Queues host commands in front of spi_intf and collects its responses; parks spi_intf on a harmless
// out-of-range write when idle. Define SPI_CMD_ADDR_CHK_EN to answer out-of-range commands locally.
module spi_cmd_seq
    import spi_cmd_pkg::*;
#(
    parameter int         CMD_DEPTH = 4,
    parameter int         RSP_DEPTH = 4,
    parameter logic [7:0] PARK_ADDR = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_din,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_wr,
    output logic [7:0] rsp_addr,
    output logic [7:0] rsp_dout,
    output logic       rsp_err,
    output logic       wr,
    output logic [7:0] addr,
    output logic [7:0] din,
    input  logic [7:0] dout,
    input  logic       done,
    input  logic       err
);

    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;

    spi_cmd_t   cmd_in, cmd_head;
    spi_rsp_t   rsp_in, rsp_head;
    logic       cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic       rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [CCW-1:0] cmd_count;
    logic [RCW-1:0] rsp_count;
    logic       unused_cmd_cnt;
    logic       unused_rsp_full;

    seq_state_e state_q, state_d;
    logic       wr_q, wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] din_q, din_d;
    int         occ_post;

    assign cmd_in    = '{wr: cmd_wr, addr: cmd_addr, din: cmd_din};
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && !cmd_full;
    assign rsp_pop   = rsp_ready && !rsp_empty;

    assign unused_cmd_cnt  = ^cmd_count;
    assign unused_rsp_full = rsp_full;

    spi_sync_fifo #(.WIDTH($bits(spi_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_push),
        .wdata (cmd_in),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    spi_sync_fifo #(.WIDTH($bits(spi_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_push),
        .wdata (rsp_in),
        .pop   (rsp_pop),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        din_d    = din_q;
        cmd_pop  = 1'b0;
        rsp_push = 1'b0;
        rsp_in   = '0;
        occ_post = 0;
        if (done) begin
            if (state_q == RUN) begin
                rsp_push    = 1'b1;
                rsp_in.wr   = wr_q;
                rsp_in.addr = addr_q;
                rsp_in.dout = (err || wr_q) ? 8'h00 : dout;
                rsp_in.err  = err;
            end
            // Launch only if the response it will produce is guaranteed a slot.
            occ_post = int'(rsp_count) + int'(rsp_push) - int'(rsp_pop);
            state_d  = PARK;
            wr_d     = 1'b1;
            addr_d   = PARK_ADDR;
            din_d    = 8'h00;
            if (!cmd_empty && occ_post < RSP_DEPTH) begin
`ifdef SPI_CMD_ADDR_CHK_EN
                if (cmd_head.addr >= 8'(MEM_WORDS)) begin
                    // One response write port: if a RUN response already uses it, retry at next done.
                    if (!rsp_push) begin
                        cmd_pop  = 1'b1;
                        rsp_push = 1'b1;
                        rsp_in   = '{wr: cmd_head.wr, addr: cmd_head.addr, dout: 8'h00, err: 1'b1};
                    end
                end else begin
                    cmd_pop = 1'b1;
                    state_d = RUN;
                    wr_d    = cmd_head.wr;
                    addr_d  = cmd_head.addr;
                    din_d   = cmd_head.din;
                end
`else
                cmd_pop = 1'b1;
                state_d = RUN;
                wr_d    = cmd_head.wr;
                addr_d  = cmd_head.addr;
                din_d   = cmd_head.din;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PARK;
            wr_q    <= 1'b1;
            addr_q  <= PARK_ADDR;
            din_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign wr   = wr_q;
    assign addr = addr_q;
    assign din  = din_q;

    assign rsp_valid = !rsp_empty;
    assign rsp_wr    = rsp_valid & rsp_head.wr;
    assign rsp_addr  = rsp_valid ? rsp_head.addr : 8'h00;
    assign rsp_dout  = rsp_valid ? rsp_head.dout : 8'h00;
    assign rsp_err   = rsp_valid & rsp_head.err;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Bench for spi_cmd_seq: emulates spi_intf timing/memory and checks issue order and responses
// against an in-order transaction model.
module tb_spi_cmd_seq;

    localparam int OP_LEN = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [7:0] cmd_addr, cmd_din;
    logic       rsp_valid, rsp_ready, rsp_wr, rsp_err;
    logic [7:0] rsp_addr, rsp_dout;
    logic       wr, done, err;
    logic [7:0] addr, din, dout;

    int checks = 0;
    int errors = 0;

    typedef struct { logic wr; logic [7:0] addr; logic [7:0] din; } cmd_e;
    typedef struct { logic wr; logic [7:0] addr; logic [7:0] dout; logic err; } rsp_e;
    cmd_e exp_issue[$];
    rsp_e exp_rsp[$];
    logic [7:0] ref_mem [32];
    logic [7:0] spi_mem [32];
    int spi_writes = 0;
    int spi_cnt = 0;

    always #5 clk = ~clk;

    spi_cmd_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_din(cmd_din),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_addr(rsp_addr), .rsp_dout(rsp_dout), .rsp_err(rsp_err),
        .wr(wr), .addr(addr), .din(din), .dout(dout), .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_push(input logic w, input logic [7:0] a, input logic [7:0] d);
        rsp_e r;
        cmd_e c;
        logic bad;
        bad    = (a >= 8'd32);
        r.wr   = w;
        r.addr = a;
        r.err  = bad;
        r.dout = (!w && !bad) ? ref_mem[a[4:0]] : 8'h00;
        if (w && !bad) ref_mem[a[4:0]] = d;
        c.wr = w; c.addr = a; c.din = d;
`ifdef SPI_CMD_ADDR_CHK_EN
        if (!bad) exp_issue.push_back(c);
`else
        exp_issue.push_back(c);
`endif
        exp_rsp.push_back(r);
    endfunction

    // spi_intf stand-in: each op lasts OP_LEN+1 cycles, done pulses for one cycle.
    initial begin
        done = 1'b0; err = 1'b0; dout = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || done) begin
                done = 1'b0; err = 1'b0; dout = 8'h00; spi_cnt = 0;
            end else if (spi_cnt == OP_LEN - 1) begin
                done = 1'b1;
                err  = (addr >= 8'd32);
                dout = (!err && !wr) ? spi_mem[addr[4:0]] : 8'h00;
                if (!err && wr) begin
                    spi_mem[addr[4:0]] = din;
                    spi_writes++;
                end
            end else begin
                spi_cnt++;
            end
        end
    end

    // Per-cycle compare: hold rule, in-order issue, response stream.
    initial begin
        logic       pdone, pwr;
        logic [7:0] paddr, pdin;
        cmd_e       c;
        rsp_e       r;
        pdone = 1'b0; pwr = 1'b1; paddr = 8'hFF; pdin = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pdone = 1'b0; pwr = 1'b1; paddr = 8'hFF; pdin = 8'h00;
                continue;
            end
            if (!pdone) begin
                chk("hold", {15'd0, wr, addr, din}, {15'd0, pwr, paddr, pdin});
            end else if (!(wr === 1'b1 && addr === 8'hFF && din === 8'h00)) begin
                chk("issue_avail", 32'(exp_issue.size() > 0), 32'd1);
                if (exp_issue.size() > 0) begin
                    c = exp_issue.pop_front();
                    chk("issue", {15'd0, wr, addr, din}, {15'd0, c.wr, c.addr, c.din});
                end
            end
            if (rsp_valid === 1'b1) begin
                chk("rsp_avail", 32'(exp_rsp.size() > 0), 32'd1);
                if (exp_rsp.size() > 0) begin
                    r = exp_rsp[0];
                    chk("rsp", {14'd0, rsp_wr, rsp_addr, rsp_dout, rsp_err},
                        {14'd0, r.wr, r.addr, r.dout, r.err});
                    if (rsp_ready) void'(exp_rsp.pop_front());
                end
            end else begin
                chk("rsp_idle", {13'd0, rsp_valid, rsp_wr, rsp_addr, rsp_dout, rsp_err}, 32'd0);
            end
            pdone = done; pwr = wr; paddr = addr; pdin = din;
        end
    end

    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
        logic acc;
        acc = 1'b0;
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_din = d;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
        end
        #2 cmd_valid = 1'b0;
        chk("send_acc", {31'd0, acc}, 32'd1);
        if (acc) model_push(w, a, d);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 500 && rsp_valid !== 1'b1; i++) @(negedge clk);
        chk("wait_rsp", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic pop_one();
        @(posedge clk); #2 rsp_ready = 1'b1;
        @(posedge clk); #2 rsp_ready = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000 && (exp_rsp.size() > 0 || exp_issue.size() > 0); i++) @(negedge clk);
        chk("drain", 32'(exp_rsp.size() + exp_issue.size()), 32'd0);
    endtask

    task automatic chk_reset_outs(input string name);
        chk(name, {10'd0, wr, addr, din, cmd_ready, rsp_valid, rsp_wr, rsp_err},
            {10'd0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        chk({name, "_rsp"}, {16'd0, rsp_addr, rsp_dout}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = 8'h00;
            spi_mem[i] = 8'h00;
        end
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_din = 8'h00; rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #10 chk_reset_outs("reset");
        #12 rst_n = 1'b1;

        // Idle: parked on the out-of-range write, nothing reaches memory.
        repeat (200) @(posedge clk);
        #2;
        chk("idle_park", {23'd0, wr, addr}, {23'd0, 1'b1, 8'hFF});
        chk("idle_mem", 32'(spi_writes), 32'd0);

        // Write then read back addr 5.
        send(1'b1, 8'd5, 8'hA5);
        send(1'b0, 8'd5, 8'h00);
        wait_rsp();
        chk("wr5_rsp", {22'd0, rsp_wr, rsp_addr, rsp_err}, {22'd0, 1'b1, 8'd5, 1'b0});
        pop_one();
        wait_rsp();
        chk("rd5_rsp", {14'd0, rsp_wr, rsp_addr, rsp_dout, rsp_err}, {14'd0, 1'b0, 8'd5, 8'hA5, 1'b0});
        pop_one();

        // Six commands with responses blocked: only four may launch.
        send(1'b1, 8'd1, 8'h11);
        send(1'b1, 8'd2, 8'h22);
        send(1'b1, 8'd3, 8'h33);
        send(1'b1, 8'd4, 8'h44);
        send(1'b0, 8'd2, 8'h00);
        send(1'b0, 8'd3, 8'h00);
        repeat (150) @(negedge clk);
        chk("rsp_full_held", 32'(exp_issue.size()), 32'd2);
        chk("rsp_full_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #2 rsp_ready = 1'b1;
        wait_drain();
        chk("mem3", {24'd0, spi_mem[3]}, 32'h33);

        // Out-of-range read.
        @(posedge clk); #2 rsp_ready = 1'b0;
        send(1'b0, 8'd40, 8'h00);
        wait_rsp();
        chk("oor_rsp", {14'd0, rsp_wr, rsp_addr, rsp_dout, rsp_err}, {14'd0, 1'b0, 8'd40, 8'h00, 1'b1});
        pop_one();
        @(posedge clk); #2 rsp_ready = 1'b1;

        // Fill the command FIFO right after a done so no launch intervenes.
        for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
        chk("saw_done", {31'd0, done}, 32'd1);
        send(1'b1, 8'd8, 8'h81);
        send(1'b1, 8'd9, 8'h92);
        send(1'b0, 8'd8, 8'h00);
        send(1'b0, 8'd9, 8'h00);
        @(negedge clk);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        #2;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'd7; cmd_din = 8'h77;
        @(posedge clk); #2 cmd_valid = 1'b0;
        for (int i = 0; i < 100 && cmd_ready !== 1'b1; i++) @(negedge clk);
        chk("ready_back", {31'd0, cmd_ready}, 32'd1);
        wait_drain();
        chk("mem7_untouched", {24'd0, spi_mem[7]}, 32'h00);

        // Reset during a read in flight: no stale response afterwards.
        send(1'b0, 8'd5, 8'h00);
        for (int i = 0; i < 100 && !(wr === 1'b0 && addr === 8'd5); i++) @(negedge clk);
        chk("rd_issued", {23'd0, wr, addr}, {23'd0, 1'b0, 8'd5});
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_rsp.delete();
        exp_issue.delete();
        #1 chk_reset_outs("mid_reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("no_stale", {31'd0, rsp_valid}, 32'd0);
        send(1'b0, 8'd9, 8'h00);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
